// File: rtl/coloring_search_ctrl_pkg.sv
// Shared constants for the graph-colouring search: graph size, the FSM
// state encoding and the edge-index to endpoint lookup table.
package coloring_search_ctrl_pkg;

    localparam int NV = 6;
    localparam int CW = 2;
    localparam int NE = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Edges enumerated lexicographically over vertex pairs i<j.
    localparam logic [2:0] EDGE_A [NE] = '{
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd1, 3'd1, 3'd1, 3'd1,
        3'd2, 3'd2, 3'd2,
        3'd3, 3'd3,
        3'd4
    };

    localparam logic [2:0] EDGE_B [NE] = '{
        3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
        3'd2, 3'd3, 3'd4, 3'd5,
        3'd3, 3'd4, 3'd5,
        3'd4, 3'd5,
        3'd5
    };

endpackage

// File: rtl/coloring_search_ctrl_checker.sv
// Combinational validity test for one candidate colouring: every colour
// must be within range and no enabled edge may join two equal colours.
module coloring_checker
    import coloring_search_ctrl_pkg::*;
(
    input  logic [NV*CW-1:0] candidate,
    input  logic [NE-1:0]    edge_mask,
    input  logic [CW-1:0]    max_color,
    output logic             valid
);

    // Range check on every vertex, then conflict check on every enabled edge.
    always_comb begin
        valid = 1'b1;
        for (int v = 0; v < NV; v++) begin
            if (candidate[v*CW +: CW] > max_color) begin
                valid = 1'b0;
            end
        end
        for (int e = 0; e < NE; e++) begin
            if (edge_mask[e] &&
                (candidate[int'(EDGE_A[e])*CW +: CW] ==
                 candidate[int'(EDGE_B[e])*CW +: CW])) begin
                valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/coloring_search_ctrl.sv
// Exhaustive graph-colouring search controller. Walks candidates upward
// from zero, one per cycle, and reports the first valid colouring.
//
//  state  | meaning
//  IDLE   | waiting for start; results from last search held
//  SEARCH | evaluating one candidate per cycle
//  DONE   | one-cycle completion pulse, results just updated
module coloring_search_ctrl
    import coloring_search_ctrl_pkg::*;
#(
    parameter int NV = 6,
    parameter int CW = 2
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [NE-1:0]      edge_mask,
    input  logic [CW-1:0]      max_color,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NV*CW-1:0]   coloring,
    output logic [NV*CW:0]     attempts
);

    localparam int CAND_W = NV * CW;
    localparam int ATT_W  = CAND_W + 1;

    state_t              state;
    logic [CAND_W-1:0]   cand;
    logic [NE-1:0]       mask_q;
    logic [CW-1:0]       maxc_q;
    logic                cand_valid;

    coloring_checker u_checker (
        .candidate (cand),
        .edge_mask (mask_q),
        .max_color (maxc_q),
        .valid     (cand_valid)
    );

    // FSM, candidate counter, configuration latch and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cand     <= '0;
            mask_q   <= '0;
            maxc_q   <= '0;
            found    <= 1'b0;
            coloring <= '0;
            attempts <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_SEARCH;
                        mask_q <= edge_mask;
                        maxc_q <= max_color;
                        cand   <= '0;
                    end
                end
                ST_SEARCH: begin
                    // Abort outranks a hit found in the same cycle.
                    if (abort) begin
                        state <= ST_IDLE;
                        found <= 1'b0;
                    end else if (cand_valid) begin
                        state    <= ST_DONE;
                        found    <= 1'b1;
                        coloring <= cand;
                        attempts <= ATT_W'(cand) + ATT_W'(1);
                    end else if (cand == {CAND_W{1'b1}}) begin
                        // Space exhausted: report the full count rather than wrapping.
                        state    <= ST_DONE;
                        found    <= 1'b0;
                        coloring <= '0;
                        attempts <= {1'b1, {CAND_W{1'b0}}};
                    end else begin
                        cand <= cand + CAND_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_SEARCH);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_coloring_search_ctrl.sv
// Scoreboard bench for coloring_search_ctrl: expected results come from a
// brute-force reference search; a monitor compares whenever done pulses.
module tb_coloring_search_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [14:0] edge_mask = '0;
    logic [1:0]  max_color = '0;
    logic        busy;
    logic        done;
    logic        found;
    logic [11:0] coloring;
    logic [12:0] attempts;

    typedef struct {
        logic        found;
        logic [11:0] coloring;
        logic [12:0] attempts;
        int          start_cyc;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    logic        last_f = 1'b0;
    logic [11:0] last_c = '0;
    logic [12:0] last_a = '0;

    coloring_search_ctrl #(.NV(6), .CW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .edge_mask (edge_mask),
        .max_color (max_color),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .coloring  (coloring),
        .attempts  (attempts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Brute force over all colourings, vertex v colour = base-4 digit v.
    function automatic void ref_search(input logic [14:0] m, input int mc,
                                       output logic f, output logic [11:0] col_out,
                                       output logic [12:0] att);
        f = 1'b0;
        col_out = '0;
        att = 13'd4096;
        for (int c = 0; c < 4096; c++) begin
            int col[6];
            bit ok;
            int e;
            ok = 1'b1;
            for (int v = 0; v < 6; v++) begin
                col[v] = (c / (1 << (2 * v))) % 4;
                if (col[v] > mc) ok = 1'b0;
            end
            e = 0;
            for (int i = 0; i < 6; i++) begin
                for (int j = i + 1; j < 6; j++) begin
                    if (m[e] && col[i] == col[j]) ok = 1'b0;
                    e++;
                end
            end
            if (ok) begin
                f = 1'b1;
                col_out = c[11:0];
                att = 13'(c + 1);
                return;
            end
        end
    endfunction

    // Monitor: count busy cycles, compare every done pulse with the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 expected no completion (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                check("found", found, e.found);
                check("coloring", coloring, e.coloring);
                check("attempts", attempts, e.attempts);
                check("latency", cyc - e.start_cyc + 1, e.attempts + 1);
                check("busy_cycles", busy_cnt, e.attempts);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_search(input logic [14:0] m, input logic [1:0] mc,
                              input bit poke, input bit with_abort);
        exp_t e;
        int n;
        edge_mask = m;
        max_color = mc;
        start = 1'b1;
        abort = with_abort;
        busy_cnt = 0;
        ref_search(m, int'(mc), e.found, e.coloring, e.attempts);
        @(posedge clk);
        #1;
        e.start_cyc = cyc;
        sbq.push_back(e);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        if (e.attempts > 4) begin
            check("held_found", found, last_f);
            check("held_coloring", coloring, last_c);
            check("held_attempts", attempts, last_a);
            if (poke) begin
                start = 1'b1;
                edge_mask = ~m;
                max_color = ~mc;
                @(negedge clk);
                start = 1'b0;
                edge_mask = m;
                max_color = mc;
            end
        end
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: busy still 1 after %0d cycles expected completion", n);
        end
        last_f = e.found;
        last_c = e.coloring;
        last_a = e.attempts;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_coloring"}, coloring, 0);
        check({tag, "_attempts"}, attempts, 0);
    endtask

    initial begin
        logic [14:0] rm;
        logic [1:0]  rc;

        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // First start on the very first edge with reset released.
        rst_n = 1'b1;
        run_search(15'h1321, 2'd3, 1'b1, 1'b0);
        run_search(15'h0000, 2'd0, 1'b0, 1'b0);
        run_search(15'h0023, 2'd1, 1'b0, 1'b0);
        run_search(15'h0023, 2'd2, 1'b0, 1'b0);
        run_search(15'h7FFF, 2'd3, 1'b1, 1'b0);
        // Start and abort together in IDLE: start must win.
        run_search(15'h1321, 2'd3, 1'b0, 1'b1);

        for (int k = 0; k < 12; k++) begin
            rm = 15'($urandom & $urandom);
            rc = 2'($urandom_range(0, 3));
            run_search(rm, rc, k[0], 1'b0);
        end

        // Abort mid-search, with ignored start pulses beforehand.
        edge_mask = 15'h7FFF;
        max_color = 2'd3;
        start = 1'b1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 100; k++) begin
            start = (k % 17 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_found", found, 0);
        check("abort_coloring", coloring, last_c);
        check("abort_attempts", attempts, last_a);
        last_f = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_stays_idle", busy, 0);

        // Reset in the middle of a search, then restart from candidate 0.
        edge_mask = 15'h7FFF;
        max_color = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        last_f = 1'b0;
        last_c = '0;
        last_a = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_search(15'h1321, 2'd3, 1'b0, 1'b0);

        repeat (5) @(negedge clk);
        if (sbq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_done: got %0d outstanding expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/coloring_search_ctrl.md
COLORING_SEARCH_CTRL -- requirements
Module: coloring_search_ctrl

Interface
REQ-001 SHALL have parameter NV, default 6, number of graph vertices (fixed at 6 in this revision).
REQ-002 SHALL have parameter CW, default 2, bits per vertex colour; candidate width = NV*CW = 12.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a new search; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate a running search.
REQ-007 SHALL have port edge_mask  input  15  edge-enable bits, sampled on accepted start.
REQ-008 SHALL have port max_color  input  2  highest legal colour index, sampled on accepted start.
REQ-009 SHALL have port busy  output  1  high while in SEARCH.
REQ-010 SHALL have port done  output  1  one-cycle pulse on search completion (not on abort).
REQ-011 SHALL have port found  output  1  last completed search produced a valid colouring.
REQ-012 SHALL have port coloring  output  12  winning candidate; vertex v colour = bits [2v+1:2v].
REQ-013 SHALL have port attempts  output  13  candidates evaluated in the last completed search (1..4096).

Function
REQ-014 Edge index SHALL be lexicographic over pairs i<j: (0,1)=0, (0,2)=1 .. (0,5)=4, (1,2)=5 .. (1,5)=8, (2,3)=9, (2,4)=10, (2,5)=11, (3,4)=12, (3,5)=13, (4,5)=14.
REQ-015 A candidate SHALL be valid iff every vertex colour <= max_color and, for every set edge_mask bit, the colours of its two endpoints differ.
REQ-016 FSM SHALL have states IDLE, SEARCH, DONE; only these transitions are legal.
REQ-017 IDLE: start=1 -> SEARCH; latch edge_mask and max_color; candidate counter := 0; found, coloring, attempts unchanged until DONE.
REQ-018 SEARCH SHALL evaluate exactly one candidate per cycle, in ascending order from 0, against the latched configuration.
REQ-019 SEARCH, candidate valid -> DONE; found := 1; coloring := candidate; attempts := candidate+1.
REQ-020 SEARCH, candidate invalid and candidate = 4095 -> DONE; found := 0; coloring := 0; attempts := 4096 (no wrap to 0).
REQ-021 SEARCH, candidate invalid and candidate < 4095 -> stay in SEARCH; candidate += 1.
REQ-022 abort=1 in SEARCH SHALL take priority over a valid candidate in the same cycle: -> IDLE, no done pulse, found := 0, coloring/attempts unchanged.
REQ-023 abort in IDLE or DONE SHALL be ignored; start in SEARCH or DONE SHALL be ignored; start and abort together in IDLE -> start wins.
REQ-024 DONE SHALL last exactly one cycle with done=1, then -> IDLE; results SHALL hold until the next DONE or reset.
REQ-025 busy SHALL equal (state==SEARCH); latency from start to done = attempts+1 cycles.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force IDLE, candidate 0, busy=0, done=0, found=0, coloring=0, attempts=0, and clear the latched configuration, regardless of state (including mid-search).
REQ-027 The first start SHALL be accepted on the first edge with rst_n=1.

Structure
REQ-028 A shared package SHALL hold NV, CW, NE=15, the FSM state enum, and the edge-index-to-endpoint constant table.
REQ-029 The validity test SHALL be a purely combinational sub-module coloring_checker (candidate, edge_mask, max_color -> valid), instantiated once.
REQ-030 coloring_search_ctrl SHALL contain only the FSM, candidate counter, configuration latch and result registers.

Verification
REQ-031 edge_mask=0x1321 (edges 01,12,15,23,34), max_color=3, start -> done after 70 cycles, found=1, coloring=0x044, attempts=69.
REQ-032 edge_mask=0x0000, max_color=0 -> found=1, coloring=0x000, attempts=1, done 2 cycles after start.
REQ-033 edge_mask=0x0023 (triangle 0-1-2), max_color=1 -> found=0, coloring=0, attempts=4096; then max_color=2 -> found=1, coloring=0x006, attempts=7.
REQ-034 edge_mask=0x7FFF (K6), max_color=3 -> found=0, attempts=4096, busy high for 4096 cycles, exactly one done pulse.
REQ-035 Start with mask 0x7FFF, abort on cycle 100 -> IDLE next cycle, no done, found=0; start pulses during SEARCH ignored.
REQ-036 rst_n=0 mid-SEARCH (mask 0x7FFF) -> all outputs zero next cycle; a start on the following cycle begins again from candidate 0.
